alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Shares the single 32-bit ALU between two requesters, e.g. the main datapath issue port and a branch/address helper unit.
- Uses round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Captures operands, drives the ALU for one cycle, then registers the result and the four flags.
- Holds the response until the granted requester accepts it.

Parameters:
- INIT_PRI, 0, requester that has priority first after reset (0 or 1).
- CNT_W, 16, width of the grant counters (used only with ALU_GRANT_CNT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  32  requester 0 operand a.
- req0_b  input  32  requester 0 operand b.
- req0_f  input  3  requester 0 ALU function code.
- req1_valid, req1_ready, req1_a, req1_b, req1_f  same as requester 0, for requester 1.
- alu_a  output  32  operand a to the ALU.
- alu_b  output  32  operand b to the ALU.
- alu_f  output  3  function code to the ALU.
- alu_result  input  32  ALU result.
- alu_zero, alu_overflow, alu_carry, alu_negative  input  1 each  ALU flags.
- rsp0_valid  output  1  response for requester 0 available.
- rsp0_ready  input  1  requester 0 accepts the response.
- rsp0_result  output  32  registered result.
- rsp0_flags  output  4  registered flags {negative, carry, overflow, zero}.
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_flags  same as above, for requester 1.

Behaviour:
- FSM has three states.
  - IDLE: if any reqN_valid is high, grant one requester. Assert its reqN_ready combinationally in that same cycle. Latch a, b, f and the grant id into op registers. Next state is CALC.
  - CALC: alu_a, alu_b and alu_f are driven from the op registers. Latch alu_result and the flags into the response registers. Next state is RESP.
  - RESP: assert rsp<gid>_valid. When rsp<gid>_ready is high, return to IDLE and set last_grant to gid.
- In IDLE and RESP, the ALU is also driven from the op registers; its output is ignored.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester that is not last_grant is granted.
  - After reset, last_grant = ~INIT_PRI.
- reqN_ready is high only in IDLE, and only for the granted requester. It is never high for both requesters, and never high in CALC or RESP.
- Latency: request accepted at cycle T, rsp valid at T+2. The earliest next accept is the cycle after the response handshake, giving a minimum of 3 cycles per operation.
- Requester waiting in RESP:
  - rsp_valid stays high and result/flags stay stable until ready.
  - The other requester is stalled (its ready stays low).
- rspN_ready while the matching rspN_valid is low: ignored.
- Function codes are passed through unchecked: 000 add, 001 sub, 010 and, 011 or, 101 slt. Other codes yield result 0, flags taken from the ALU.
- Reset, including mid-operation:
  - State goes to IDLE; any in-flight operation is dropped and no response is issued.
  - Op and response registers clear to 0; last_grant = ~INIT_PRI.
  - All ready and valid outputs are 0; rsp results and flags are 0; alu_a, alu_b and alu_f are 0.

Optional Feature:
- Macro: ALU_GRANT_CNT_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1, each CNT_W bits.
  - Each counter increments on its requester's accept handshake and saturates at all-ones (no wrap).
  - Both clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/include:
  - ALU function-code constants (ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101).
  - FSM state encodings (S_IDLE=2'd0, S_CALC=2'd1, S_RESP=2'd2).
  - Flag bit positions (FLG_Z=0, FLG_V=1, FLG_C=2, FLG_N=3).
- Natural sub-module: rr_arb2. It is a combinational two-way round-robin picker taking valid[1:0] and last_grant, producing a one-hot grant. It is instantiated in the arbiter; the ALU itself is instantiated outside.

Test Plan:
- Req0 only, a=5, b=7, f=000 → req0_ready at T, rsp0_valid at T+2, rsp0_result=12, flags=0000. Hold rsp0_ready low 3 cycles → outputs stable throughout.
- Req0 and req1 both valid from reset (INIT_PRI=0); req0 sub 3−3, req1 slt −1<1 → req0 is served first with result 0, flags 0001. req1 is served next with result 1, flags 0000.
- Both valid continuously for 4 operations with rsp_ready tied high → grant order 0,1,0,1; accepts exactly 3 cycles apart.
- Req1 add a=0x7FFFFFFF, b=1 → rsp1_result=0x80000000, flags {N=1, C=0, V=1, Z=0} = 1010.
- Assert reset during CALC → next cycle IDLE, no rsp valid ever appears. A new req0 afterwards completes normally.
- With ALU_GRANT_CNT_EN and CNT_W=2: 5 req1 accepts → grant_cnt1=3 (saturated), grant_cnt0=0.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
// Shared types and constants for the two-port ALU share arbiter.
// Function codes, FSM states, flag positions and op/response bundles.
package alu_share_arb_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam int FLG_Z = 0;
    localparam int FLG_V = 1;
    localparam int FLG_C = 2;
    localparam int FLG_N = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic        gid;
    } op_t;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
    } rsp_t;

    function automatic logic [3:0] pack_flags(
        input logic n,
        input logic c,
        input logic v,
        input logic z
    );
        logic [3:0] fl;
        fl        = '0;
        fl[FLG_N] = n;
        fl[FLG_C] = c;
        fl[FLG_V] = v;
        fl[FLG_Z] = z;
        return fl;
    endfunction

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin picker: one-hot grant from valid and last winner.
// On contention the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one 32-bit ALU between two requesters with round-robin grant.
// Optional per-requester saturating grant counters: ALU_GRANT_CNT_EN.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter logic INIT_PRI = 1'b0,
    parameter int   CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [2:0]       req0_f,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [2:0]       req1_f,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_f,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    input  logic             alu_negative,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_result,
    output logic [3:0]       rsp0_flags,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_result,
    output logic [3:0]       rsp1_flags
`ifdef ALU_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("CNT_W must be at least 1");
    end

    state_e     state_q, state_d;
    op_t        op_q, op_d;
    rsp_t       rsp_q, rsp_d;
    logic       last_q, last_d;
    logic [1:0] grant;
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;

    assign rsp_ready = {rsp1_ready, rsp0_ready};

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_q),
        .grant      (grant)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rsp_d     = rsp_q;
        last_d    = last_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    req_ready = grant;
                    op_d.gid  = grant[1];
                    op_d.a    = grant[1] ? req1_a : req0_a;
                    op_d.b    = grant[1] ? req1_b : req0_b;
                    op_d.f    = grant[1] ? req1_f : req0_f;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                rsp_d.result = alu_result;
                rsp_d.flags  = pack_flags(alu_negative, alu_carry,
                                          alu_overflow, alu_zero);
                state_d      = S_RESP;
            end
            S_RESP: begin
                rsp_valid[op_q.gid] = 1'b1;
                if (rsp_ready[op_q.gid]) begin
                    last_d  = op_q.gid;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Handshake outputs stay quiet while reset is being applied.
        if (reset) begin
            req_ready = '0;
            rsp_valid = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rsp_q   <= '0;
            last_q  <= ~INIT_PRI;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rsp_q   <= rsp_d;
            last_q  <= last_d;
        end
    end

    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];
    assign alu_a       = op_q.a;
    assign alu_b       = op_q.b;
    assign alu_f       = op_q.f;
    assign rsp0_valid  = rsp_valid[0];
    assign rsp1_valid  = rsp_valid[1];
    assign rsp0_result = rsp_q.result;
    assign rsp1_result = rsp_q.result;
    assign rsp0_flags  = rsp_q.flags;
    assign rsp1_flags  = rsp_q.flags;

`ifdef ALU_GRANT_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req_ready[0] && cnt0_q != '1) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (req_ready[1] && cnt1_q != '1) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule
